// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Op encodings match the RV32M funct3 field.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MdMul    = 3'b000,
        MdMulh   = 3'b001,
        MdMulhsu = 3'b010,
        MdMulhu  = 3'b011,
        MdDiv    = 3'b100,
        MdDivu   = 3'b101,
        MdRem    = 3'b110,
        MdRemu   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup,
        StDone
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring shift-subtract divide.
// The accumulator ends holding {hi, lo} product, or {remainder, quotient}.
module muldiv_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                is_div_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic                done_o,
    output logic [2*XLEN-1:0]   acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_div_q;
    logic              active_q;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, b_q};
        if (!is_div_q) begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (rem_sh >= {1'b0, b_q}) begin
            acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    assign done_o = active_q && (cnt_q == CNT_W'(XLEN - 1));
    assign acc_o  = acc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            active_q <= 1'b0;
        end else if (start_i) begin
            acc_q    <= {{XLEN{1'b0}}, a_i};
            b_q      <= b_i;
            cnt_q    <= '0;
            is_div_q <= is_div_i;
            active_q <= 1'b1;
        end else if (active_q) begin
            acc_q <= acc_d;
            if (done_o) begin
                cnt_q    <= '0;
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: handshake FSM, sign handling and fast path around
// the iterative unsigned datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    md_state_e         state_q;
    md_op_e            op_in, op_q;
    logic              neg_q, rneg_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   result_q;

    logic              sa, sb, accept, fast, iter_start, iter_done;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res, fix_res;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0]   min_neg;

    assign op_in   = md_op_e'(op);
    assign min_neg = {1'b1, {(XLEN-1){1'b0}}};
    assign sa      = a[XLEN-1] && (op_in inside {MdMulh, MdMulhsu, MdDiv, MdRem});
    assign sb      = b[XLEN-1] && (op_in inside {MdMulh, MdDiv, MdRem});
    assign a_mag   = sa ? -a : a;
    assign b_mag   = sb ? -b : b;

    // Divide-by-zero and the single signed-overflow case bypass the datapath.
    assign fast = op[2] && ((b == '0) ||
                  ((op_in inside {MdDiv, MdRem}) && (a == min_neg) && (b == '1)));
    assign fast_res   = (b == '0) ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign accept     = (state_q == StIdle) && in_valid && !flush;
    assign iter_start = accept && !fast;

    muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (iter_start),
        .is_div_i (op[2]),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .done_o   (iter_done),
        .acc_o    (acc)
    );

    always_comb begin
        prod = neg_q ? -acc : acc;
        unique case (op_q)
            MdMul:                     fix_res = prod[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: fix_res = prod[2*XLEN-1:XLEN];
            MdDiv, MdDivu:             fix_res = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:                   fix_res = rneg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= MdMul;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q   <= op_in;
                        neg_q  <= sa ^ sb;
                        rneg_q <= sa;
                        if (fast) begin
                            result_q    <= fast_res;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (iter_done) state_q <= StFixup;
                end
                StFixup: begin
                    result_q    <= fix_res;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, backpressure, flush and reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, measure edges from the accept edge to out_valid, check result, consume.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_lat, input logic [31:0] exp_res,
                          input bit consume);
        int lat;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, result, exp_res);
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check_eq({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
        end
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int seen;
        vecs[0]  = '{"mul",     3'b000, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFEB};
        vecs[1]  = '{"mulh",    3'b001, 32'h80000000, 32'h80000000, 33, 32'h40000000};
        vecs[2]  = '{"mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE};
        vecs[3]  = '{"mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFF};
        vecs[4]  = '{"div",     3'b100, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD};
        vecs[5]  = '{"rem",     3'b110, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF};
        vecs[6]  = '{"divu",    3'b101, 32'd100,      32'd7,        33, 32'd14};
        vecs[7]  = '{"remu",    3'b111, 32'd100,      32'd7,        33, 32'd2};
        vecs[8]  = '{"divu0",   3'b101, 32'd5,        32'd0,        0,  32'hFFFFFFFF};
        vecs[9]  = '{"remu0",   3'b111, 32'd5,        32'd0,        0,  32'd5};
        vecs[10] = '{"divovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 0,  32'h80000000};
        vecs[11] = '{"removf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 0,  32'd0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b,
                                 vecs[i].lat, vecs[i].res, 1'b1);

        // Backpressure: result held and no new accept while out_ready stays low.
        run_op("bp", 3'b000, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFEB, 1'b0);
        in_valid = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold_res", result, 32'hFFFFFFEB);
            check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
        check_eq("bp_release_valid", {31'b0, out_valid}, 32'd0);

        // Flush together with a request in IDLE drops the request.
        in_valid = 1'b1; flush = 1'b1; op = 3'b101; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_idle_busy", {31'b0, busy}, 32'd0);

        // Flush ten cycles into CALC.
        op = 3'b101; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("flush_busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("flush_no_valid", seen, 32'd0);

        // Reset mid-CALC, then a fresh multiply.
        op = 3'b000; a = 32'd55; b = 32'd66; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("mrst_busy", {31'b0, busy}, 32'd0);
        check_eq("mrst_result", result, 32'd0);
        run_op("mul3x4", 3'b000, 32'd3, 32'd4, 33, 32'd12, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
